// File: rtl/ggt_pkg.sv
// Shared definitions for the GCD job sequencer: sequencer states and
// default sizing constants used by ggt_job_sequencer and ggt_pair_fifo.
package ggt_pkg;

    localparam int GGT_W       = 16;
    localparam int GGT_TIMEOUT = 70000;
    localparam int GGT_DEPTH   = 4;

    // Job sequencer states, in the order a normal job visits them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        OUT    = 3'd4
    } ggt_state_e;

    // A pair with a zero operand has gcd equal to the other operand.
    function automatic logic is_zero_pair(input logic [GGT_W-1:0] a,
                                          input logic [GGT_W-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/ggt_pair_fifo.sv
// Synchronous FIFO holding packed operand pairs {A,B} for the job sequencer.
// Pointers wrap modulo DEPTH (power of two); full/empty derive from a
// registered occupancy count. A push while full is taken only together
// with a pop, so the slot freed by the pop is reused in the same cycle.
module ggt_pair_fifo #(
    parameter int W2    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          push,
    input  logic [W2-1:0] wdata,
    input  logic          pop,
    output logic [W2-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W2-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pair storage; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ggt_job_sequencer.sv
// Upstream feeder for ggt_top: queues operand pairs, starts the GCD core
// once per pair, waits for its valid (with a watchdog) and returns each
// result tagged with its operands on a valid/ready port.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A source never withdraws valid or changes its
// payload before the transfer; ready may be asserted independently of valid.
//
// Optional build macro GGT_ZERO_BYPASS_EN: pairs with a zero operand skip
// the core and complete immediately with result A|B.
module ggt_job_sequencer
    import ggt_pkg::*;
#(
    parameter int W           = GGT_W,
    parameter int DEPTH       = GGT_DEPTH,
    parameter int TIMEOUT_CYC = GGT_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         pair_valid_i,
    output logic         pair_ready_o,
    input  logic [W-1:0] zahl1_i,
    input  logic [W-1:0] zahl2_i,
    output logic         ggt_start_o,
    output logic [W-1:0] ggt_zahl1_o,
    output logic [W-1:0] ggt_zahl2_o,
    input  logic         ggt_valid_i,
    input  logic [W-1:0] ggt_ergebnis_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] res_zahl1_o,
    output logic [W-1:0] res_zahl2_o,
    output logic [W-1:0] res_ergebnis_o,
    output logic         res_err_o,
    output logic [15:0]  jobs_done_o,
    output ggt_state_e   dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    ggt_state_e      state;
    logic            ready_en;
    logic            start_q;
    logic            res_valid_q;
    logic            res_err_q;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    res_erg_q;
    logic [WD_W-1:0] wd;
    logic [15:0]     jobs_q;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2*W-1:0]  fifo_head;
    logic [W-1:0]    head_a;
    logic [W-1:0]    head_b;

    // ready_en keeps pair_ready_o low in the reset cycle and rises one
    // cycle after release; afterwards readiness is just "not full".
    assign pair_ready_o = ready_en & ~fifo_full;
    assign fifo_push    = pair_valid_i & pair_ready_o;
    assign fifo_pop     = (state == IDLE) & ~fifo_empty;
    assign head_a       = fifo_head[2*W-1:W];
    assign head_b       = fifo_head[W-1:0];

    ggt_pair_fifo #(
        .W2    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_i (rst_i),
        .push  (fifo_push),
        .wdata ({zahl1_i, zahl2_i}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Operands stay in op_a/op_b from the pop until the next pop, so they
    // serve both as the core inputs and as the result tags.
    assign ggt_start_o    = start_q;
    assign ggt_zahl1_o    = op_a;
    assign ggt_zahl2_o    = op_b;
    assign res_valid_o    = res_valid_q;
    assign res_zahl1_o    = op_a;
    assign res_zahl2_o    = op_b;
    assign res_ergebnis_o = res_erg_q;
    assign res_err_o      = res_err_q;
    assign jobs_done_o    = jobs_q;
    assign dbg_state      = state;

    // Job sequencer: pop, start pulse, settle, wait with watchdog, hand off.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state       <= IDLE;
            ready_en    <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            res_erg_q   <= '0;
            wd          <= '0;
            jobs_q      <= '0;
        end else begin
            ready_en <= 1'b1;
            start_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_a <= head_a;
                        op_b <= head_b;
`ifdef GGT_ZERO_BYPASS_EN
                        if (is_zero_pair(head_a, head_b)) begin
                            res_erg_q   <= head_a | head_b;
                            res_err_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                            state       <= OUT;
                        end else begin
                            start_q <= 1'b1;
                            state   <= START;
                        end
`else
                        start_q <= 1'b1;
                        state   <= START;
`endif
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    // Core valid may still be high from the previous job.
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    if (ggt_valid_i) begin
                        res_erg_q   <= ggt_ergebnis_i;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                    end else if (wd == WD_LAST) begin
                        res_erg_q   <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        jobs_q      <= jobs_q + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ggt_job_sequencer.sv
// Self-checking bench for ggt_job_sequencer with a behavioural GCD core.
module tb_ggt_job_sequencer;
    import ggt_pkg::*;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic         pair_valid = 1'b0;
    logic         pair_ready;
    logic [W-1:0] z1 = '0, z2 = '0;
    logic         ggt_start;
    logic [W-1:0] ggt_zahl1, ggt_zahl2;
    logic         ggt_valid;
    logic [W-1:0] ggt_erg;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_z1, res_z2, res_erg;
    logic         res_err;
    logic [15:0]  jobs_done;
    ggt_state_e   dbg_state;

    // ---------------- timeout DUT signals (core never answers) ----------------
    logic         t_pair_valid = 1'b0;
    logic         t_pair_ready;
    logic [W-1:0] t_z1 = '0, t_z2 = '0;
    logic         t_start;
    logic [W-1:0] t_gz1, t_gz2;
    logic         t_res_valid;
    logic         t_res_ready = 1'b0;
    logic [W-1:0] t_rz1, t_rz2, t_rerg;
    logic         t_rerr;
    logic [15:0]  t_jobs;
    ggt_state_e   t_dbg;

    ggt_job_sequencer #(.W(W), .DEPTH(4), .TIMEOUT_CYC(70000)) dut (
        .clk(clk), .rst_i(rst_i),
        .pair_valid_i(pair_valid), .pair_ready_o(pair_ready),
        .zahl1_i(z1), .zahl2_i(z2),
        .ggt_start_o(ggt_start), .ggt_zahl1_o(ggt_zahl1), .ggt_zahl2_o(ggt_zahl2),
        .ggt_valid_i(ggt_valid), .ggt_ergebnis_i(ggt_erg),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_zahl1_o(res_z1), .res_zahl2_o(res_z2),
        .res_ergebnis_o(res_erg), .res_err_o(res_err),
        .jobs_done_o(jobs_done), .dbg_state(dbg_state)
    );

    ggt_job_sequencer #(.W(W), .DEPTH(4), .TIMEOUT_CYC(20)) dut_t (
        .clk(clk), .rst_i(rst_i),
        .pair_valid_i(t_pair_valid), .pair_ready_o(t_pair_ready),
        .zahl1_i(t_z1), .zahl2_i(t_z2),
        .ggt_start_o(t_start), .ggt_zahl1_o(t_gz1), .ggt_zahl2_o(t_gz2),
        .ggt_valid_i(1'b0), .ggt_ergebnis_i(16'h0000),
        .res_valid_o(t_res_valid), .res_ready_i(t_res_ready),
        .res_zahl1_o(t_rz1), .res_zahl2_o(t_rz2),
        .res_ergebnis_o(t_rerg), .res_err_o(t_rerr),
        .jobs_done_o(t_jobs), .dbg_state(t_dbg)
    );

    // ---------------- reference model ----------------
    int chk_cnt = 0;
    int err_cnt = 0;
    logic [3*W:0] exp_q[$];
    int start_cnt = 0;
    int jobs_exp = 0;

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // Behavioural core: valid is a level that stays high until the next
    // start and lingers through the cycle after START (stale valid), then
    // answers after a random delay with gcd of the operands it sees.
    logic core_stale = 1'b0;
    int   core_cnt = 0;
    initial begin
        ggt_valid = 1'b0;
        ggt_erg = '0;
    end
    always @(posedge clk) begin
        if (!rst_i) begin
            ggt_valid  <= 1'b0;
            core_stale <= 1'b0;
            core_cnt   <= 0;
        end else if (ggt_start) begin
            core_stale <= 1'b1;
            core_cnt   <= $urandom_range(4, 12);
        end else if (core_stale) begin
            core_stale <= 1'b0;
            ggt_valid  <= 1'b0;
            ggt_erg    <= 16'hFFFF;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                ggt_valid <= 1'b1;
                ggt_erg   <= gcd(ggt_zahl1, ggt_zahl2);
            end
        end
    end

    // Scoreboard / monitor on the result port of the main DUT.
    logic         hold_prev = 1'b0;
    logic [3*W:0] prev_res;
    always @(negedge clk) begin
        logic [3*W:0] got;
        logic [3*W:0] e;
        if (rst_i) begin
            got = {res_z1, res_z2, res_erg, res_err};
            if (ggt_start) start_cnt++;
            if (hold_prev && res_valid) begin
                chk_cnt++;
                if (got !== prev_res) begin
                    err_cnt++;
                    $display("FAIL res_hold: got %h required %h", got, prev_res);
                end
            end
            if (res_valid && res_ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL res_unexpected: got %h required none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        err_cnt++;
                        $display("FAIL res_data: got a=%0d b=%0d g=%0d err=%0b required a=%0d b=%0d g=%0d err=%0b",
                                 res_z1, res_z2, res_erg, res_err,
                                 e[3*W:2*W+1], e[2*W:W+1], e[W:1], e[0]);
                    end
                end
                jobs_exp = (jobs_exp + 1) % 65536;
            end
            hold_prev = res_valid && !res_ready;
            prev_res  = got;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_i = 1'b0;
        pair_valid = 1'b0;
        res_ready = 1'b0;
        t_pair_valid = 1'b0;
        t_res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        jobs_exp = 0;
        start_cnt = 0;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        pair_valid = 1'b1;
        z1 = a;
        z2 = b;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge clk);
            acc = pair_ready;
            @(posedge clk);
            #1;
        end
        pair_valid = 1'b0;
        if (acc) exp_q.push_back({a, b, gcd(a, b), 1'b0});
        else begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL push_timeout: pair (%0d,%0d) not accepted, required accepted", a, b);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic check_jobs(input string name, input int exp_starts, input int exp_jobs);
        chk_cnt++;
        if (start_cnt != exp_starts) begin
            err_cnt++;
            $display("FAIL %s_starts: got %0d required %0d", name, start_cnt, exp_starts);
        end
        chk_cnt++;
        if (jobs_done !== 16'(exp_jobs) || jobs_exp != exp_jobs) begin
            err_cnt++;
            $display("FAIL %s_jobs: got %0d (model %0d) required %0d", name, jobs_done, jobs_exp, exp_jobs);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({pair_ready, ggt_start, res_valid, res_err, jobs_done} !== '0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got rdy=%b st=%b rv=%b err=%b jobs=%0d required all 0",
                     pair_ready, ggt_start, res_valid, res_err, jobs_done);
        end
        chk_cnt++;
        if ({ggt_zahl1, ggt_zahl2, res_z1, res_z2, res_erg} !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h required 0", {ggt_zahl1, ggt_zahl2, res_z1, res_z2, res_erg});
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (pair_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_ready_early: got %b required 0", pair_ready);
        end
        @(negedge clk);
        chk_cnt++;
        if (pair_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready_after: got %b required 1", pair_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        res_ready = 1'b1;
        push_pair(16'd238, 16'd356);
        @(negedge clk);
        chk_cnt++;
        if (ggt_start !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_start_early: got %b required 0", ggt_start);
        end
        @(negedge clk);
        chk_cnt++;
        if (ggt_start !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_start_latency: got %b required 1", ggt_start);
        end
        @(posedge clk);
        #1;
        wait_drain(200);
        check_jobs("basic", 1, 1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        res_ready = 1'b1;
        push_pair(16'd24255, 16'd12540);
        push_pair(16'd48, 16'd18);
        push_pair(16'd17, 16'd5);
        wait_drain(300);
        repeat (5) @(posedge clk);
        #1;
        check_jobs("b2b", 3, 3);
    endtask

    task automatic test_backpressure();
        bit took = 1'b0;
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_pair(W'($urandom_range(1, 65535)), W'($urandom_range(1, 65535)));
        repeat (40) @(posedge clk);
        #1;
        pair_valid = 1'b1;
        z1 = 16'd99;
        z2 = 16'd33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pair_ready) took = 1'b1;
            @(posedge clk);
            #1;
        end
        pair_valid = 1'b0;
        chk_cnt++;
        if (took) begin
            err_cnt++;
            $display("FAIL bp_ready_full: got ready=1 required 0");
        end
        @(negedge clk);
        chk_cnt++;
        if (res_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_res_waiting: got %b required 1", res_valid);
        end
        @(posedge clk);
        #1;
        chk_cnt++;
        if (start_cnt != 1) begin
            err_cnt++;
            $display("FAIL bp_single_inflight: got %0d starts required 1", start_cnt);
        end
        res_ready = 1'b1;
        wait_drain(600);
        repeat (40) @(posedge clk);
        #1;
        check_jobs("bp", 5, 5);
    endtask

    task automatic test_random();
        bit done = 1'b0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    push_pair(W'($urandom_range(1, 65535)), W'($urandom_range(1, 400)));
                end
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 6000 && !(done && exp_q.size() == 0); k++) begin
                    res_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        res_ready = 1'b1;
        wait_drain(500);
        repeat (5) @(posedge clk);
        #1;
        check_jobs("rand", 24, 24);
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        do_reset();
        res_ready = 1'b1;
        push_pair(16'd9, 16'd6);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ggt_start;
            @(posedge clk);
            #1;
        end
        chk_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL midrst_start: got no start required start");
        end
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_cnt++;
        if ({pair_ready, ggt_start, res_valid, res_err, jobs_done,
             ggt_zahl1, ggt_zahl2, res_z1, res_z2, res_erg} !== '0) begin
            err_cnt++;
            $display("FAIL midrst_outputs: got zahl=%0d,%0d rv=%b st=%b required all 0",
                     ggt_zahl1, ggt_zahl2, res_valid, ggt_start);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        start_cnt = 0;
        jobs_exp = 0;
        repeat (10) @(posedge clk);
        #1;
        chk_cnt++;
        if (start_cnt != 0) begin
            err_cnt++;
            $display("FAIL midrst_fifo_empty: got %0d starts required 0", start_cnt);
        end
        push_pair(16'd12, 16'd8);
        wait_drain(200);
        check_jobs("midrst", 1, 1);
    endtask

    task automatic test_timeout();
        bit acc = 1'b0;
        int s_idx = -1;
        int v_idx = -1;
        do_reset();
        t_res_ready = 1'b0;
        t_pair_valid = 1'b1;
        t_z1 = 16'd5;
        t_z2 = 16'd7;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = t_pair_ready;
            @(posedge clk);
            #1;
        end
        t_pair_valid = 1'b0;
        for (int i = 0; i < 100 && v_idx < 0; i++) begin
            @(negedge clk);
            if (t_start && s_idx < 0) s_idx = i;
            if (t_res_valid) v_idx = i;
            @(posedge clk);
            #1;
        end
        chk_cnt++;
        if (s_idx != 1) begin
            err_cnt++;
            $display("FAIL to_start_latency: got %0d required 1", s_idx);
        end
        chk_cnt++;
        if (v_idx - s_idx != 22) begin
            err_cnt++;
            $display("FAIL to_latency: got %0d required 22", v_idx - s_idx);
        end
        @(negedge clk);
        chk_cnt++;
        if ({t_res_valid, t_rz1, t_rz2, t_rerg, t_rerr} !== {1'b1, 16'd5, 16'd7, 16'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL to_result: got v=%b a=%0d b=%0d g=%0d err=%b required v=1 a=5 b=7 g=0 err=1",
                     t_res_valid, t_rz1, t_rz2, t_rerg, t_rerr);
        end
        @(posedge clk);
        #1;
        t_res_ready = 1'b1;
        @(posedge clk);
        #1;
        t_res_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (t_res_valid !== 1'b0 || t_jobs !== 16'd1) begin
            err_cnt++;
            $display("FAIL to_handoff: got v=%b jobs=%0d required v=0 jobs=1", t_res_valid, t_jobs);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef GGT_ZERO_BYPASS_EN
    task automatic test_bypass();
        int v_idx = -1;
        do_reset();
        res_ready = 1'b0;
        push_pair(16'd0, 16'd42);
        for (int i = 0; i < 10 && v_idx < 0; i++) begin
            @(negedge clk);
            if (res_valid) v_idx = i;
            @(posedge clk);
            #1;
        end
        chk_cnt++;
        if (v_idx < 0 || v_idx > 1) begin
            err_cnt++;
            $display("FAIL bypass_latency: got %0d required <=1", v_idx);
        end
        res_ready = 1'b1;
        push_pair(16'd0, 16'd0);
        wait_drain(50);
        repeat (5) @(posedge clk);
        #1;
        check_jobs("bypass", 0, 2);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_timeout();
`ifdef GGT_ZERO_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

endmodule
